video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480 VGA counter block.
- Separate front-porch, sync and back-porch parameters per axis, plus programmable sync polarity.
- Pixel-clock-enable input, so it runs from a faster system clock.
- Fully registered outputs: syncs, data-enable, active-pixel coordinates, line/frame start strobes, and line/frame prefetch strobes that let the sprite/tile fetch engines start early.

Parameters:
- H_ACTIVE, 640, visible columns
- H_FRONT, 16, horizontal front porch columns
- H_SYNC, 96, hsync width in columns
- H_BACK, 48, horizontal back porch columns
- V_ACTIVE, 480, visible rows
- V_FRONT, 10, vertical front porch rows
- V_SYNC, 2, vsync width in rows
- V_BACK, 33, vertical back porch rows
- HSYNC_POL, 0, asserted hsync level (0 = active-low)
- VSYNC_POL, 0, asserted vsync level
- PREFETCH_COLS, 32, line-prefetch lead in columns; legal range 1..H_TOTAL-H_ACTIVE
- PREFETCH_ROWS, 32, frame-prefetch lead in rows; legal range 1..V_TOTAL-V_ACTIVE
- FRAME_W, 8, frame counter width (optional feature only)
- Derived values:
  - H_TOTAL = sum of the four H parameters
  - V_TOTAL = sum of the four V parameters
  - COL_W = $clog2(H_TOTAL)
  - ROW_W = $clog2(V_TOTAL)

Ports:
- i_clk, in, 1, system clock
- i_reset, in, 1, synchronous active-high reset
- i_pix_en, in, 1, pixel tick; counters advance only on cycles where it is high
- o_col, out, COL_W, column counter, 0..H_TOTAL-1
- o_row, out, ROW_W, row counter, 0..V_TOTAL-1
- o_hsync, out, 1, horizontal sync, polarity applied
- o_vsync, out, 1, vertical sync, polarity applied
- o_de, out, 1, active-video data enable
- o_line_start, out, 1, one-cycle strobe at col 0 of an active row
- o_frame_start, out, 1, one-cycle strobe at (0,0)
- o_line_prefetch, out, 1, one-cycle strobe PREFETCH_COLS ticks before an active line starts
- o_frame_prefetch, out, 1, one-cycle strobe PREFETCH_ROWS rows before the frame starts

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high; reset wins over i_pix_en.
- Raster layout:
  - Column order: active 0..H_ACTIVE-1, front porch, sync, back porch.
  - Rows use the same order.
  - Col 0 / row 0 is the first visible pixel.
- Reset values:
  - o_col = H_TOTAL-1, o_row = V_TOTAL-1.
  - o_de = 0; o_hsync = !HSYNC_POL; o_vsync = !VSYNC_POL.
  - All strobes 0.
  - The first i_pix_en after reset moves to (0,0) and fires o_frame_start and o_line_start.
- Counter update (on a cycle with i_pix_en=1):
  - col = H_TOTAL-1 → col <= 0 and row advances; otherwise col+1.
  - row = V_TOTAL-1 with col wrapping → row <= 0.
- Output decode:
  - All level outputs are decoded from the next-state counters and registered, so they align exactly with o_col/o_row; no combinational paths to outputs.
  - o_de = (col < H_ACTIVE) && (row < V_ACTIVE).
  - hsync asserted for H_ACTIVE+H_FRONT <= col < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync asserted for rows in V_ACTIVE+V_FRONT .. +V_SYNC-1, over the whole row including col 0.
- Strobes:
  - Each strobe is high for exactly one i_clk cycle: the cycle after the tick that entered the position.
  - It is cleared on the next clock regardless of i_pix_en.
  - Level outputs hold while i_pix_en=0.
- o_line_prefetch fires on entering col H_TOTAL-PREFETCH_COLS when the following row is < V_ACTIVE. This includes the last row (V_TOTAL-1), which precedes row 0.
- o_frame_prefetch fires on entering (0, V_TOTAL-PREFETCH_ROWS).
- Wrap-around: the line wrap and frame wrap happen on the same tick; o_line_start and o_frame_start are both asserted.
- Reset mid-frame: the next cycle shows the reset values; no strobe fires from the aborted frame.
- Elaboration: an illegal parameter (PREFETCH out of range, any zero-width region) causes an $error.

Optional Feature:
- Macro: VIDEO_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output o_frame_count[FRAME_W-1:0].
  - Reset value 0.
  - Increments on the same tick that raises o_frame_start, so the first frame after reset reads 1.
  - Wraps 2^FRAME_W-1 → 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then i_pix_en=1 constant → cycle 1: col=0, row=0, o_de=1, o_frame_start=1, o_line_start=1; next cycle both strobes 0.
- Defaults, free run → hsync low exactly at cols 656..751 of every row; o_de low at col 640; vsync low at rows 490..491; frame period 420000 ticks.
- i_pix_en one cycle in four → counters advance every 4th clock; strobes still one clock wide; o_line_prefetch at col 768 on rows 0..478 and 524, never on rows 479..523.
- Row 493 entered at col 0 → o_frame_prefetch single pulse; row 0 entered 32*800 ticks later.
- Reset asserted at (300,200) with i_pix_en=1 → next cycle col=799, row=524, o_de=0, syncs inactive, no strobes.
- With VIDEO_TIMING_FRAME_CNT_EN and FRAME_W=2 → count runs 1,2,3,0 over four frames; HSYNC_POL=1 build gives hsync high at cols 656..751.

Source files
------------

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Parametrised raster timing generator with per-axis porches,
//            programmable sync polarity, pixel-clock enable, start and
//            prefetch strobes. Optional frame counter under the macro
//            VIDEO_TIMING_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter bit HSYNC_POL     = 1'b0,
    parameter bit VSYNC_POL     = 1'b0,
    parameter int PREFETCH_COLS = 32,
    parameter int PREFETCH_ROWS = 32,
    parameter int FRAME_W       = 8,
    localparam int H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int COL_W        = $clog2(H_TOTAL),
    localparam int ROW_W        = $clog2(V_TOTAL)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_pix_en,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic             o_line_start,
    output logic             o_frame_start,
    output logic             o_line_prefetch,
    output logic             o_frame_prefetch
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_W-1:0] o_frame_count
`endif
);

    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0] C_H_ACTIVE = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] C_HS_START = COL_W'(H_ACTIVE + H_FRONT);
    localparam logic [COL_W-1:0] C_HS_END   = COL_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [COL_W-1:0] C_LPF_COL  = COL_W'(H_TOTAL - PREFETCH_COLS);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0] C_V_ACTIVE = ROW_W'(V_ACTIVE);
    localparam logic [ROW_W-1:0] C_V_ACT_M1 = ROW_W'(V_ACTIVE - 1);
    localparam logic [ROW_W-1:0] C_VS_START = ROW_W'(V_ACTIVE + V_FRONT);
    localparam logic [ROW_W-1:0] C_VS_END   = ROW_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [ROW_W-1:0] C_FPF_ROW  = ROW_W'(V_TOTAL - PREFETCH_ROWS);

    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        PREFETCH_COLS < 1 || PREFETCH_COLS > H_TOTAL - H_ACTIVE ||
        PREFETCH_ROWS < 1 || PREFETCH_ROWS > V_TOTAL - V_ACTIVE ||
        FRAME_W < 1) begin : g_bad_params
        $error("video_timing_gen: illegal parameter set");
    end

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic de_q, de_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;
    logic line_pf_q, line_pf_d;
    logic frame_pf_q, frame_pf_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_pix_en) begin
            if (col_q == C_COL_LAST) begin
                col_d = '0;
                row_d = (row_q == C_ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // Levels decode from the next-state position so they line up with o_col/o_row.
        de_d    = (col_d < C_H_ACTIVE) && (row_d < C_V_ACTIVE);
        hsync_d = ((col_d >= C_HS_START) && (col_d < C_HS_END)) ? HSYNC_POL : !HSYNC_POL;
        vsync_d = ((row_d >= C_VS_START) && (row_d < C_VS_END)) ? VSYNC_POL : !VSYNC_POL;

        // Strobes only fire on the tick that enters the position.
        line_start_d  = i_pix_en && (col_d == '0) && (row_d < C_V_ACTIVE);
        frame_start_d = i_pix_en && (col_d == '0) && (row_d == '0);
        line_pf_d     = i_pix_en && (col_d == C_LPF_COL) &&
                        ((row_d < C_V_ACT_M1) || (row_d == C_ROW_LAST));
        frame_pf_d    = i_pix_en && (col_d == '0) && (row_d == C_FPF_ROW);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            col_q         <= C_COL_LAST;
            row_q         <= C_ROW_LAST;
            hsync_q       <= !HSYNC_POL;
            vsync_q       <= !VSYNC_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            line_pf_q     <= 1'b0;
            frame_pf_q    <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            line_pf_q     <= line_pf_d;
            frame_pf_q    <= frame_pf_d;
        end
    end

    assign o_col            = col_q;
    assign o_row            = row_q;
    assign o_hsync          = hsync_q;
    assign o_vsync          = vsync_q;
    assign o_de             = de_q;
    assign o_line_start     = line_start_q;
    assign o_frame_start    = frame_start_q;
    assign o_line_prefetch  = line_pf_q;
    assign o_frame_prefetch = frame_pf_q;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_start_d ? frame_cnt_q + FRAME_W'(1) : frame_cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_frame_count = frame_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Brief    : Scoreboard bench for video_timing_gen on a small raster, with a
//            linear-position reference model and randomized pixel enables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int PC = 4,  PR = 3, FW = 2;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int TOTAL = HT * VT;
    localparam int CW = $clog2(HT);
    localparam int RW = $clog2(VT);
    localparam int N_CYCLES = 4000;

    typedef struct {
        int col; int row; int hs; int vs; int de;
        int ls; int fs; int lp; int fp; int fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic hsync, vsync, de, line_start, frame_start, line_pf, frame_pf;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [FW-1:0] frame_count;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   armed  = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
        .PREFETCH_COLS(PC), .PREFETCH_ROWS(PR), .FRAME_W(FW)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_pix_en        (pix_en),
        .o_col           (col),
        .o_row           (row),
        .o_hsync         (hsync),
        .o_vsync         (vsync),
        .o_de            (de),
        .o_line_start    (line_start),
        .o_frame_start   (frame_start),
        .o_line_prefetch (line_pf),
        .o_frame_prefetch(frame_pf)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
        ,
        .o_frame_count   (frame_count)
`endif
    );

    // Reference: the raster is a single linear position 0..TOTAL-1; reset parks it at TOTAL-1.
    function automatic exp_t model(input int pos, input bit tick, input int fc);
        exp_t e;
        int c, r;
        c = pos % HT;
        r = pos / HT;
        e.col = c;
        e.row = r;
        e.de  = (c < HA && r < VA) ? 1 : 0;
        e.hs  = (c >= HA + HF && c < HA + HF + HS) ? int'(HPOL) : int'(!HPOL);
        e.vs  = (r >= VA + VF && r < VA + VF + VS) ? int'(VPOL) : int'(!VPOL);
        e.ls  = (tick && c == 0 && r < VA) ? 1 : 0;
        e.fs  = (tick && pos == 0) ? 1 : 0;
        e.lp  = (tick && c == HT - PC && ((r + 1) % VT) < VA) ? 1 : 0;
        e.fp  = (tick && c == 0 && r == VT - PR) ? 1 : 0;
        e.fc  = fc;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    initial begin
        int  pos;
        int  fc;
        bit  tick;
        rst    = 1'b1;
        pix_en = 1'b0;
        pos    = TOTAL - 1;
        fc     = 0;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            if (cyc < 800)       pix_en = (cyc >= 2);
            else if (cyc < 1800) pix_en = (cyc % 4 == 0);
            else                 pix_en = ($urandom_range(0, 3) != 0);
            rst = (cyc < 2) || (cyc == 1000) || (cyc == 2500) ||
                  ($urandom_range(0, 1499) == 0);
            if (cyc == 2500) pix_en = 1'b1;
            if (rst) begin
                pos  = TOTAL - 1;
                fc   = 0;
                tick = 1'b0;
            end else if (pix_en) begin
                pos  = (pos + 1) % TOTAL;
                tick = 1'b1;
                if (pos == 0) fc = (fc + 1) % (1 << FW);
            end else begin
                tick = 1'b0;
            end
            q.push_back(model(pos, tick, fc));
            armed = 1'b1;
        end
        @(posedge clk);
        #2;
        armed = 1'b0;
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("col",            int'(col),         e.col);
                check("row",            int'(row),         e.row);
                check("hsync",          int'(hsync),       e.hs);
                check("vsync",          int'(vsync),       e.vs);
                check("de",             int'(de),          e.de);
                check("line_start",     int'(line_start),  e.ls);
                check("frame_start",    int'(frame_start), e.fs);
                check("line_prefetch",  int'(line_pf),     e.lp);
                check("frame_prefetch", int'(frame_pf),    e.fp);
`ifdef VIDEO_TIMING_FRAME_CNT_EN
                check("frame_count",    int'(frame_count), e.fc);
`endif
            end else if (armed) begin
                check("scoreboard_underflow", 0, 1);
            end
        end
    end

endmodule
`default_nettype wire
